// File: rtl/pipelined_prefix_adder_pkg.sv
// Shared helpers for the Kogge-Stone prefix adder: prefix cell, level span, mask arithmetic.
// Latency: n/a (functions only).
// Backpressure: n/a.
package pipelined_prefix_adder_pkg;

    // Group generate/propagate combine: (g,p) o (g',p') = (g | p&g', p&p')
    function automatic logic [1:0] prefix_cell(input logic g_hi, input logic p_hi,
                                               input logic g_lo, input logic p_lo);
        return {g_hi | (p_hi & g_lo), p_hi & p_lo};
    endfunction

    // Distance to the partner bit at a given prefix level: 1, 2, 4, ...
    function automatic int span(input int level);
        return 1 << level;
    endfunction

    function automatic int popcount(input logic [31:0] m);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += int'(m[i]);
        end
        return n;
    endfunction

    // Pipeline stage whose register sits after prefix level 'level'.
    // Stage 0 is the input register; each set mask bit below 'level' adds one stage.
    function automatic int stage_after_level(input logic [31:0] mask, input int level);
        return 1 + popcount(mask & ((32'd1 << level) - 32'd1));
    endfunction

endpackage

// File: rtl/pipelined_prefix_adder_level.sv
// One Kogge-Stone prefix level, optionally followed by a pipeline register.
// Latency: 0 cycles when REG=0, 1 cycle when REG=1.
// Backpressure: register only captures when load is high, otherwise holds.
module prefix_level
    import pipelined_prefix_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SPAN  = 1,
    parameter int REG   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] g_in,
    input  logic [WIDTH-1:0] p_in,
    input  logic [WIDTH:0]   x_in,
    output logic [WIDTH-1:0] g_out,
    output logic [WIDTH-1:0] p_out,
    output logic [WIDTH:0]   x_out
);

    logic [WIDTH-1:0] g_d;
    logic [WIDTH-1:0] p_d;

    // Bits below SPAN have no partner at this level and pass straight through.
    for (genvar j = 0; j < WIDTH; j++) begin : g_bit
        if (j >= SPAN) begin : g_cell
            assign {g_d[j], p_d[j]} = prefix_cell(g_in[j], p_in[j], g_in[j-SPAN], p_in[j-SPAN]);
        end else begin : g_pass
            assign g_d[j] = g_in[j];
            assign p_d[j] = p_in[j];
        end
    end

    if (REG != 0) begin : g_reg
        logic [WIDTH-1:0] g_q;
        logic [WIDTH-1:0] p_q;
        logic [WIDTH:0]   x_q;

        // Stage register: capture the level result when this stage loads.
        always_ff @(posedge clk) begin
            if (rst) begin
                g_q <= '0;
                p_q <= '0;
                x_q <= '0;
            end else if (load) begin
                g_q <= g_d;
                p_q <= p_d;
                x_q <= x_in;
            end
        end

        assign g_out = g_q;
        assign p_out = p_q;
        assign x_out = x_q;
    end else begin : g_comb
        logic unused_comb;
        assign unused_comb = ^{clk, rst, load};
        assign g_out = g_d;
        assign p_out = p_d;
        assign x_out = x_in;
    end

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Kogge-Stone add/sub with sum, carry-out, overflow and zero flags; prefix registers per PIPE_MASK.
// Latency: N = 2 + popcount(PIPE_MASK) register stages from input transfer to out_valid.
// Backpressure: per-stage valid bits, bubbles collapse; in_ready is combinational from out_ready.
module pipelined_prefix_adder
    import pipelined_prefix_adder_pkg::*;
#(
    parameter int                WIDTH     = 32,
    parameter int                LEVELS    = $clog2(WIDTH),
    parameter logic [LEVELS-1:0] PIPE_MASK = LEVELS'(5'b00100)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c0,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NSTG = 2 + popcount(32'(PIPE_MASK));

    // ---------------- valid chain ----------------
    logic [NSTG-1:0] v_q, v_d, rdy, load, up_v;
    logic            rdy_chain;

    // Valid arriving at each stage: stage 0 from the input port, others from the stage before.
    assign up_v = {v_q[NSTG-2:0], in_valid};

    // Ready ripples back from out_ready: a stage can take a beat if empty or if it empties this edge.
    always_comb begin
        rdy       = '0;
        rdy_chain = out_ready;
        for (int k = NSTG - 1; k >= 0; k--) begin
            rdy[k]    = ~v_q[k] | rdy_chain;
            rdy_chain = rdy[k];
        end
        load = up_v & rdy;
        v_d  = (rdy & up_v) | (~rdy & v_q);
    end

    // Valid bits; reset drops every in-flight beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[NSTG-1];

    // ---------------- S0 input register ----------------
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             ci_q, ci_d;

    // Subtraction becomes A + ~B + 1, so the effective operand and carry are captured here.
    always_comb begin
        a_d  = a_q;
        b_d  = b_q;
        ci_d = ci_q;
        if (load[0]) begin
            a_d  = a;
            b_d  = sub ? ~b : b;
            ci_d = sub | c0;
        end
    end

    // Input stage register.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            ci_q <= 1'b0;
        end else begin
            a_q  <= a_d;
            b_q  <= b_d;
            ci_q <= ci_d;
        end
    end

    // ---------------- g/p precompute and prefix tree ----------------
    logic [WIDTH-1:0] g_lv [LEVELS+1];
    logic [WIDTH-1:0] p_lv [LEVELS+1];
    logic [WIDTH:0]   x_lv [LEVELS+1];
    logic [WIDTH-1:0] h0, g0;

    // Carry-in acts as g[-1] with p[-1]=0, so it folds directly into bit 0's generate.
    always_comb begin
        h0    = a_q ^ b_q;
        g0    = a_q & b_q;
        g0[0] = g0[0] | (h0[0] & ci_q);
    end

    assign g_lv[0] = g0;
    assign p_lv[0] = h0;
    assign x_lv[0] = {h0, ci_q};   // half-sums plus carry-in travel alongside for the final XOR

    for (genvar i = 0; i < LEVELS; i++) begin : g_level
        localparam int STG = stage_after_level(32'(PIPE_MASK), i);
        prefix_level #(
            .WIDTH (WIDTH),
            .SPAN  (span(i)),
            .REG   (int'(PIPE_MASK[i]))
        ) u_level (
            .clk   (clk),
            .rst   (rst),
            .load  (load[STG]),
            .g_in  (g_lv[i]),
            .p_in  (p_lv[i]),
            .x_in  (x_lv[i]),
            .g_out (g_lv[i+1]),
            .p_out (p_lv[i+1]),
            .x_out (x_lv[i+1])
        );
    end

    // ---------------- output register and flags ----------------
    logic [WIDTH-1:0] gc, sum_nx, sum_q, sum_d;
    logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
    logic             unused_p;

    assign gc       = g_lv[LEVELS];
    assign unused_p = ^p_lv[LEVELS];

    // sum[i] = h[i] ^ carry into bit i; bit 0's carry is the carry-in itself.
    assign sum_nx = x_lv[LEVELS][WIDTH:1] ^ {gc[WIDTH-2:0], x_lv[LEVELS][0]};

    // Output stage captures result and flags together; holds while downstream stalls.
    always_comb begin
        sum_d  = sum_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        zero_d = zero_q;
        if (load[NSTG-1]) begin
            sum_d  = sum_nx;
            cout_d = gc[WIDTH-1];
            ovf_d  = gc[WIDTH-1] ^ gc[WIDTH-2];
            zero_d = ~|sum_nx;
        end
    end

    // Output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Directed bench for pipelined_prefix_adder: default 32-bit/3-stage instance and a 16-bit/2-stage one.
// Latency: checked per instance against its stage count.
// Backpressure: stall window exercises hold, fill and simultaneous in/out transfer.
module tb_pipelined_prefix_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, c0 = 1'b0, sub = 1'b0;
    logic        out_valid, out_ready = 1'b1, cout, ovf, zero;
    logic [31:0] a = '0, b = '0, sum;

    logic        in_valid16 = 1'b0, in_ready16, c0_16 = 1'b0, sub16 = 1'b0;
    logic        out_valid16, out_ready16 = 1'b1, cout16, ovf16, zero16;
    logic [15:0] a16 = '0, b16 = '0, sum16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipelined_prefix_adder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c0(c0), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    pipelined_prefix_adder #(.WIDTH(16), .PIPE_MASK(4'b0000)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .c0(c0_16), .sub(sub16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .sum(sum16), .cout(cout16), .ovf(ovf16), .zero(zero16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {cout, ovf, zero, sum}
    function automatic logic [34:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic mc0, input logic msub);
        logic [31:0] bb;
        logic [32:0] r;
        logic        v;
        bb = msub ? ~mb : mb;
        r  = {1'b0, ma} + {1'b0, bb} + {32'd0, (msub | mc0)};
        v  = (ma[31] == bb[31]) && (r[31] != ma[31]);
        return {r[32], v, (r[31:0] == 32'd0), r[31:0]};
    endfunction

    // Single beat into an empty pipe; result expected after exactly 3 edges.
    task automatic directed(input string tag, input logic [31:0] da, input logic [31:0] db,
                            input logic dc0, input logic dsub, input logic [31:0] esum,
                            input logic ecout, input logic eovf, input logic ezero);
        a = da; b = db; c0 = dc0; sub = dsub; in_valid = 1'b1;
        #1;
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        chk({tag, "_early"}, out_valid, 1'b0);
        tick();
        chk({tag, "_out_valid"}, out_valid, 1'b1);
        chk({tag, "_sum"}, sum, esum);
        chk({tag, "_cout"}, cout, ecout);
        chk({tag, "_ovf"}, ovf, eovf);
        chk({tag, "_zero"}, zero, ezero);
        tick();
    endtask

    task automatic new_beat();
        a = $urandom; b = $urandom;
        c0 = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
    endtask

    // Streams n beats with in_valid held high; out_ready low for stall_len cycles from stall_at.
    task automatic run_stream(input int n, input int stall_at, input int stall_len,
                              output int popped, output int first_pop, output int last_pop,
                              output int acc_stall);
        logic [34:0] expq[$];
        logic [34:0] e;
        logic [31:0] held_sum;
        logic        held, xfer;
        int          sent, cyc;
        expq.delete();
        sent = 0; cyc = 0; held = 1'b0; held_sum = '0;
        popped = 0; first_pop = -1; last_pop = -1; acc_stall = 0;
        new_beat();
        in_valid = 1'b1;
        while (popped < n && cyc < 200) begin
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            #1;
            if (stall_len > 0 && cyc == stall_at + stall_len && in_valid)
                chk("full_pipe_in_ready", in_ready, 1'b1);
            xfer = in_valid && in_ready;
            if (xfer) begin
                expq.push_back(model(a, b, c0, sub));
                sent++;
                if (!out_ready) acc_stall++;
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("spurious_out", 64'(expq.size()), 64'd1);
                end else begin
                    e = expq.pop_front();
                    chk("stream_result", {cout, ovf, zero, sum}, e);
                end
                popped++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                held = 1'b0;
            end else if (out_valid) begin
                if (held) chk("stall_hold_sum", sum, held_sum);
                else begin
                    held = 1'b1;
                    held_sum = sum;
                end
            end
            tick();
            cyc++;
            if (xfer) begin
                if (sent < n) new_beat();
                else in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    int popped, first_pop, last_pop, acc_stall;

    initial begin
        // 1. Reset with in_valid held high on both instances
        rst = 1'b1; in_valid = 1'b1; in_valid16 = 1'b1; a = 32'd3; b = 32'd4; a16 = 16'd3; b16 = 16'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_out_valid16", out_valid16, 1'b0);
        end
        rst = 1'b0; in_valid = 1'b0; in_valid16 = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);
        chk("post_rst_in_ready16", in_ready16, 1'b1);
        chk("post_rst_out_valid", out_valid, 1'b0);
        chk("post_rst_flags", {cout, ovf, zero, sum}, 35'd0);
        tick();
        chk("idle_out_valid", out_valid, 1'b0);

        // 2. Carry wrap to zero
        directed("wrap", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);

        // 3. Overflow, borrow, carry-in used/ignored
        directed("add_ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        directed("sub_borrow", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        directed("sub_c0_ign", 32'd7, 32'd5, 1'b1, 1'b1, 32'd2, 1'b1, 1'b0, 1'b0);
        directed("add_c0", 32'd1, 32'd2, 1'b1, 1'b0, 32'd4, 1'b0, 1'b0, 1'b0);
        directed("sub_ovf", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        directed("sub_zero", 32'd5, 32'd5, 1'b0, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1);

        // 4. 16 back-to-back beats, no stall
        run_stream(16, 1000, 0, popped, first_pop, last_pop, acc_stall);
        chk("stream_count", 64'(popped), 64'd16);
        chk("stream_back_to_back", 64'(last_pop - first_pop), 64'd15);

        // 5. Stall for 6 cycles: exactly 3 beats fill the pipe, then release
        run_stream(10, 0, 6, popped, first_pop, last_pop, acc_stall);
        chk("stall_count", 64'(popped), 64'd10);
        chk("stall_accepted", 64'(acc_stall), 64'd3);
        tick();
        chk("drained", out_valid, 1'b0);

        // 6a. Reset with 2 beats in flight
        a = 32'd10; b = 32'd20; c0 = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tick();
        a = 32'd30;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("flush_out_valid", out_valid, 1'b0);
            tick();
        end

        // 6b. WIDTH=16, PIPE_MASK=0: latency 2
        a16 = 16'hFFFF; b16 = 16'd1; c0_16 = 1'b0; sub16 = 1'b0; in_valid16 = 1'b1;
        #1;
        chk("w16_in_ready", in_ready16, 1'b1);
        tick();
        in_valid16 = 1'b0;
        chk("w16_early", out_valid16, 1'b0);
        tick();
        chk("w16_out_valid", out_valid16, 1'b1);
        chk("w16_result", {cout16, ovf16, zero16, sum16}, {1'b1, 1'b0, 1'b1, 16'h0000});
        tick();
        chk("w16_drained", out_valid16, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
